// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the transmit/receive state encoding.
// The transmitter's optional parity stage is enabled with UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;
  localparam int UART_OVS     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/transmitter_if.sv
// Byte handshake between a TX source (fifo / register block) and the transmitter.
// With UART_TX_PARITY_EN the parity_odd select travels with the handshake.
interface transmitter_if
  import uart_pkg::*;
#(
  parameter int DBIT = UART_DBIT
);
  logic            tx_start;
  logic [DBIT-1:0] tx_dataIn;
  logic            tx_busy;
  logic            tx_doneTick;
`ifdef UART_TX_PARITY_EN
  logic            parity_odd;

  modport master (output tx_start, tx_dataIn, parity_odd, input tx_busy, tx_doneTick);
  modport slave  (input tx_start, tx_dataIn, parity_odd, output tx_busy, tx_doneTick);
`else
  modport master (output tx_start, tx_dataIn, input tx_busy, tx_doneTick);
  modport slave  (input tx_start, tx_dataIn, output tx_busy, tx_doneTick);
`endif
endinterface

// File: rtl/transmitter.sv
// UART serial transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd via parity_odd).
module transmitter
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int OVS     = UART_OVS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tick,
  transmitter_if.slave bus,
  output logic         tx
);

  localparam int CW = $clog2(SB_TICK) + 1;
  localparam logic [CW-1:0] OVS_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST   = 3'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [CW-1:0]   s_cnt_q, s_cnt_d;
  logic [2:0]      n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Refuse a start during the doneTick cycle so frames get at least one idle-high clk.
        if (bus.tx_start && !done_q) begin
          b_d     = bus.tx_dataIn;
          s_cnt_d = '0;
          state_d = ST_START;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.tx_dataIn;
`endif
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = ST_DATA;
          end else begin
            s_cnt_d = s_cnt_q + CW'(1);
          end
        end
      end
      ST_DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == N_LAST) state_d = AFTER_DATA;
            else                   n_cnt_d = n_cnt_q + 3'd1;
          end else begin
            s_cnt_d = s_cnt_q + CW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q ^ bus.parity_odd;
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            state_d = ST_STOP;
          end else begin
            s_cnt_d = s_cnt_q + CW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            s_cnt_d = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            s_cnt_d = s_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is the flop output, so it trails the state register by one clk.
  assign tx              = tx_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_doneTick = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: per-tick frame checks, serial decode, busy/back-to-back/reset cases.
module tb_transmitter;
  import uart_pkg::*;

  localparam int TPT    = 4;               // clks per s_tick
  localparam int BITCLK = UART_OVS * TPT;  // clks per bit
`ifdef UART_TX_PARITY_EN
  localparam int NBIT = 11;
`else
  localparam int NBIT = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tick = 1'b0;
  logic tx;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  transmitter_if #(.DBIT(8)) bus ();

  transmitter #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_tick(s_tick),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (TPT - 1) @(negedge clk);
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
  end

  always @(negedge clk) if (bus.tx_doneTick === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Lands just after the negedge preceding a tick-consuming posedge.
  task automatic next_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * TPT; i++) begin
      @(negedge clk);
      #1;
      if (s_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Tick-aligned send: every s_tick of the frame must see the expected line level.
  task automatic send_chk(input string tag, input logic [7:0] d, input bit inject);
    bit         ok;
    int         bad_lvl = 0;
    int         bad_busy = 0;
    int         d0;
    logic [7:0] got = '0;
    next_tick(ok);
    bus.tx_dataIn = d;
    bus.tx_start  = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    #1;
    bus.tx_start = 1'b0;
    for (int k = 0; k < NBIT * 16; k++) begin
      next_tick(ok);
      if (!ok) bad_lvl++;
      if (tx !== exp_bit(d, k / 16)) bad_lvl++;
      if (bus.tx_busy !== 1'b1) bad_busy++;
      if (k >= 16 && k < 144 && k % 16 == 8) got[k/16-1] = tx;
      if (inject && k == 80) begin
        bus.tx_dataIn = 8'h3C;
        bus.tx_start  = 1'b1;
      end
      if (inject && k == 81) bus.tx_start = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_byte"}, 32'(got), 32'(d));
    chk({tag, "_levels"}, bad_lvl, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_idle"}, {bus.tx_busy, tx}, 32'b01);
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Mid-bit sampling from the observed falling edge; returns mid stop bit.
  task automatic decode(output logic [7:0] d, output logic p, output logic fr_ok);
    logic s0;
    repeat (BITCLK / 2) @(negedge clk);
    s0 = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (BITCLK) @(negedge clk);
      d[i] = tx;
    end
    p = 1'b0;
`ifdef UART_TX_PARITY_EN
    repeat (BITCLK) @(negedge clk);
    p = tx;
`endif
    repeat (BITCLK) @(negedge clk);
    fr_ok = (s0 === 1'b0) && (tx === 1'b1);
  endtask

  initial begin
    bit         ok;
    logic [7:0] d;
    logic       p, fr;
    int         gap, d0, bad;

    bus.tx_start  = 1'b1;
    bus.tx_dataIn = 8'h55;
`ifdef UART_TX_PARITY_EN
    bus.parity_odd = 1'b0;
`endif

    // reset held with tx_start asserted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", bus.tx_busy, 0);
      chk("rst_done", bus.tx_doneTick, 0);
    end
    bus.tx_start = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("rst_nostart", bad, 0);

    send_chk("f55", 8'h55, 1'b0);
    send_chk("fF0", 8'hF0, 1'b0);
    send_chk("fFF", 8'hFF, 1'b0);
    send_chk("f0F", 8'h0F, 1'b0);

    // start pulse mid-DATA is dropped, nothing queued
    send_chk("fA5", 8'hA5, 1'b1);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("busy_noqueue", bad, 0);

    // back-to-back with tx_start held high
    bus.tx_dataIn = 8'h81;
    bus.tx_start  = 1'b1;
    wait_fall(ok);
    chk("b2b_fall1", ok, 1);
    decode(d, p, fr);
    chk("b2b_byte1", d, 8'h81);
    chk("b2b_frame1", fr, 1);
    ok = 1'b0;
    for (int i = 0; i < 4 * BITCLK; i++) begin
      @(negedge clk);
      if (bus.tx_doneTick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_done1", ok, 1);
    bus.tx_dataIn = 8'h7E;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (tx === 1'b0) break;
    end
    chk("b2b_gap", gap, 3);
    bus.tx_start = 1'b0;
    decode(d, p, fr);
    chk("b2b_byte2", d, 8'h7E);
    chk("b2b_frame2", fr, 1);
    repeat (BITCLK) @(negedge clk);

    // reset during data bit 3 of 0x00
    bus.tx_dataIn = 8'h00;
    bus.tx_start  = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_fall(ok);
    chk("rmid_fall", ok, 1);
    repeat (BITCLK / 2 + 4 * BITCLK) @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid_tx", tx, 1);
    chk("rmid_busy", bus.tx_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12 * BITCLK) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("rmid_quiet", bad, 0);
    chk("rmid_nodone", done_cnt - d0, 0);

    bus.tx_dataIn = 8'h99;
    bus.tx_start  = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_fall(ok);
    chk("r99_fall", ok, 1);
    decode(d, p, fr);
    chk("r99_byte", d, 8'h99);
    chk("r99_frame", fr, 1);
    repeat (BITCLK) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    bus.tx_dataIn = 8'h07;
    bus.tx_start  = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_fall(ok);
    decode(d, p, fr);
    chk("par07_byte", d, 8'h07);
    chk("par07_bit", p, 1);
    chk("par07_frame", fr, 1);
    repeat (BITCLK) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
